mprj_io_buffer_sync: RTL and testbench
======================================

// Module: mprj_io_buffer_sync
// PURPOSE
//  Parametrised, registered successor to the management GPIO pad buffer.
//  Sits between the management SoC and the user-project IO ring.
//  Pad-side inputs: per-bit N-stage synchroniser, then per-bit glitch filter.
//  Pad-side outputs/OEBs: aligned retiming pipeline with freeze; in_changed strobe on any filtered input edge.
// PARAMETERS
//  NUM_IO       38  number of gpio in/out channels (`MPRJ_IO_PADS)
//  NUM_OEB       3  number of buffered output-enable (active-low) bits
//  SYNC_STAGES   2  synchroniser flops on input path; legal 1..4
//  FILT_CYCLES   4  consecutive stable cycles to accept an input change; 0 = filter bypass
//  OUT_STAGES    1  register stages on out/oeb path; legal 1..4
// PORTS
//  clock              in   1        single system clock, all flops rising edge
//  reset              in   1        synchronous, active-high
//  freeze             in   1        1 = hold out/oeb pipeline contents
//  mgmt_gpio_in       in   NUM_IO   raw pad inputs (asynchronous)
//  mgmt_gpio_in_buf   out  NUM_IO   synchronised + filtered inputs
//  in_changed         out  1        1-cycle pulse: any in_buf bit updated
//  mgmt_gpio_oeb      in   NUM_OEB  output enables from mgmt core
//  mgmt_gpio_oeb_buf  out  NUM_OEB  retimed output enables
//  mgmt_gpio_out      in   NUM_IO   output data from mgmt core
//  mgmt_gpio_out_buf  out  NUM_IO   retimed output data
// BEHAVIOUR
//  Clocking: one clock; reset synchronous active-high, sampled on rising edge.
//  Reset values: in_buf=0, in_changed=0, out_buf=0, oeb_buf=all 1s (pads hi-Z).
//   Sync flops and filter counters cleared to 0; every out/oeb stage to out_buf/oeb_buf reset value.
//  Reset beats freeze and any in-flight filter count; mid-op reset discards pending changes.
//  Input sync: bit i through SYNC_STAGES flops -> s[i]; no cross-bit coherency.
//  Glitch filter, per bit, counter cnt[i] width $clog2(FILT_CYCLES+1):
//   s[i]==in_buf[i]               -> cnt<=0
//   s[i]!=in_buf[i], cnt<FILT-1   -> cnt<=cnt+1
//   s[i]!=in_buf[i], cnt==FILT-1  -> in_buf[i]<=s[i], cnt<=0
//   Any cycle where s returns to in_buf value restarts count (pulse < FILT_CYCLES rejected).
//   FILT_CYCLES==0: in_buf<=s every cycle (one register stage, no counter).
//  Input latency: stable pad change visible on in_buf after
//   SYNC_STAGES+FILT_CYCLES rising edges (SYNC_STAGES+1 when FILT_CYCLES==0).
//  in_changed: registered; 1 in the cycle after in_buf changes (same edge as in_buf update
//   produces pulse next cycle); multiple bits same cycle -> single pulse.
//  Output path: out and oeb share one OUT_STAGES-deep shift pipeline; latency = OUT_STAGES
//   edges; out/oeb bits from the same input cycle always appear in the same output cycle.
//  freeze=1: no stage of out/oeb pipeline loads; outputs hold; inputs issued
//   while frozen are dropped. freeze=0: shifting resumes next edge. Input path ignores freeze.
//  freeze asserted and deasserted same cycle as input change: sampled value per edge only.
//  Width rules: no arithmetic on data; counters saturate-free (reset to 0 on accept).
//  Out-of-range parameters: elaboration-time $error.
// TESTING
//  T1 reset: assert reset 2 cycles with random inputs -> in_buf=0, out_buf=0, oeb_buf=3'b111, in_changed=0.
//  T2 input latency: defaults, in[5] 0->1 held -> in_buf[5]=1 exactly 6 edges later; in_changed=1 on edge 7 only.
//  T3 glitch: in[0] high 3 cycles then low (FILT=4) -> in_buf[0] stays 0, in_changed never pulses;
//     high 4 cycles -> accepted.
//  T4 output pipeline: OUT_STAGES=3, out=38'h2A_AAAA_AAAA, oeb=3'b010 at cycle 0 -> both appear at cycle 3 together.
//  T5 freeze: out_buf=0x1; freeze=1, drive out=0x3F for 5 cycles -> out_buf stays 0x1; freeze=0 -> 0x3F after OUT_STAGES edges.
//  T6 reset mid-filter: in[7] high 2 cycles then reset pulse -> in_buf[7]=0, count restarts full FILT_CYCLES.

Source files
------------

// File: rtl/mprj_io_buffer_sync.sv
// Registered management GPIO buffer: synchronised and glitch-filtered pad inputs,
// plus a freezable retiming pipeline on the out/oeb path toward the pads.
module mprj_io_buffer_sync #(
    parameter int unsigned NUM_IO      = 38,
    parameter int unsigned NUM_OEB     = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned OUT_STAGES  = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               freeze,
    input  logic [NUM_IO-1:0]  mgmt_gpio_in,
    output logic [NUM_IO-1:0]  mgmt_gpio_in_buf,
    output logic               in_changed,
    input  logic [NUM_OEB-1:0] mgmt_gpio_oeb,
    output logic [NUM_OEB-1:0] mgmt_gpio_oeb_buf,
    input  logic [NUM_IO-1:0]  mgmt_gpio_out,
    output logic [NUM_IO-1:0]  mgmt_gpio_out_buf
);

    localparam int unsigned PW    = NUM_IO + NUM_OEB;
    localparam int unsigned CNT_W = (FILT_CYCLES > 0) ? $clog2(FILT_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PIPE_RST = {{NUM_IO{1'b0}}, {NUM_OEB{1'b1}}};

    if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("mprj_io_buffer_sync: SYNC_STAGES=%0d outside 1..4", SYNC_STAGES);
    end
    if (OUT_STAGES < 1 || OUT_STAGES > 4) begin : g_bad_out
        $error("mprj_io_buffer_sync: OUT_STAGES=%0d outside 1..4", OUT_STAGES);
    end
    if (NUM_IO < 1 || NUM_OEB < 1) begin : g_bad_width
        $error("mprj_io_buffer_sync: NUM_IO and NUM_OEB must be at least 1");
    end

    logic [NUM_IO-1:0] r_sync [SYNC_STAGES];
    logic [NUM_IO-1:0] w_s;
    logic [NUM_IO-1:0] r_in_buf;
    logic [NUM_IO-1:0] w_in_buf_nxt;
    logic              r_upd;
    logic              r_in_changed;
    logic [PW-1:0]     r_pipe [OUT_STAGES];

    // Per-bit synchroniser chain; bits are independent, no cross-bit coherency.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= mgmt_gpio_in;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    if (FILT_CYCLES == 0) begin : g_nofilt
        assign w_in_buf_nxt = w_s;
    end else begin : g_filt
        logic [CNT_W-1:0] r_cnt     [NUM_IO];
        logic [CNT_W-1:0] w_cnt_nxt [NUM_IO];

        // A change is accepted only after FILT_CYCLES consecutive disagreeing samples.
        always_comb begin
            w_in_buf_nxt = r_in_buf;
            for (int i = 0; i < int'(NUM_IO); i++) begin
                w_cnt_nxt[i] = '0;
                if (w_s[i] != r_in_buf[i]) begin
                    if (r_cnt[i] == CNT_W'(FILT_CYCLES - 1)) begin
                        w_in_buf_nxt[i] = w_s[i];
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < int'(NUM_IO); i++) begin
                    r_cnt[i] <= '0;
                end
            end else begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    // r_upd marks the edge that updated in_buf; in_changed follows one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_buf     <= '0;
            r_upd        <= 1'b0;
            r_in_changed <= 1'b0;
        end else begin
            r_in_buf     <= w_in_buf_nxt;
            r_upd        <= |(w_in_buf_nxt ^ r_in_buf);
            r_in_changed <= r_upd;
        end
    end

    // out and oeb travel as one word so both halves always stay aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < int'(OUT_STAGES); k++) begin
                r_pipe[k] <= PIPE_RST;
            end
        end else if (!freeze) begin
            r_pipe[0] <= {mgmt_gpio_out, mgmt_gpio_oeb};
            for (int k = 1; k < int'(OUT_STAGES); k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign mgmt_gpio_in_buf  = r_in_buf;
    assign in_changed        = r_in_changed;
    assign mgmt_gpio_out_buf = r_pipe[OUT_STAGES-1][PW-1:NUM_OEB];
    assign mgmt_gpio_oeb_buf = r_pipe[OUT_STAGES-1][NUM_OEB-1:0];

endmodule

// File: tb/tb_mprj_io_buffer_sync.sv
// Bench for mprj_io_buffer_sync: directed scenarios plus random traffic, checked
// every cycle against a window/queue based reference model.
module tb_mprj_io_buffer_sync;

    localparam int unsigned NUM_IO  = 38;
    localparam int unsigned NUM_OEB = 3;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned FILT    = 4;
    localparam int unsigned OUTS    = 3;
    localparam int unsigned OW      = NUM_IO + NUM_OEB;

    logic               clock = 1'b0;
    logic               reset;
    logic               freeze;
    logic [NUM_IO-1:0]  pad;
    logic [NUM_IO-1:0]  mgmt_gpio_in_buf;
    logic               in_changed;
    logic [NUM_OEB-1:0] goeb;
    logic [NUM_OEB-1:0] mgmt_gpio_oeb_buf;
    logic [NUM_IO-1:0]  gout;
    logic [NUM_IO-1:0]  mgmt_gpio_out_buf;

    always #5 clock = ~clock;

    mprj_io_buffer_sync #(
        .NUM_IO(NUM_IO), .NUM_OEB(NUM_OEB), .SYNC_STAGES(SYNC),
        .FILT_CYCLES(FILT), .OUT_STAGES(OUTS)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .freeze            (freeze),
        .mgmt_gpio_in      (pad),
        .mgmt_gpio_in_buf  (mgmt_gpio_in_buf),
        .in_changed        (in_changed),
        .mgmt_gpio_oeb     (goeb),
        .mgmt_gpio_oeb_buf (mgmt_gpio_oeb_buf),
        .mgmt_gpio_out     (gout),
        .mgmt_gpio_out_buf (mgmt_gpio_out_buf)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [NUM_IO-1:0] m_sync [$];
    logic [NUM_IO-1:0] m_hist [$];
    logic [OW-1:0]     m_pipe [$];
    logic [NUM_IO-1:0] m_in_buf;
    logic              m_upd;
    logic              m_chg;

    int          first;
    int          pulses;
    logic        seen_high;
    logic [NUM_IO-1:0] flip;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_sync.delete();
        for (int i = 0; i < int'(SYNC); i++) m_sync.push_back('0);
        m_hist.delete();
        m_pipe.delete();
        for (int i = 0; i < int'(OUTS); i++) m_pipe.push_back({{NUM_IO{1'b0}}, {NUM_OEB{1'b1}}});
        m_in_buf = '0;
        m_upd    = 1'b0;
        m_chg    = 1'b0;
    endfunction

    // One rising edge of the model: pad delay line, sliding window filter, freezable delay queue.
    function automatic void model_edge(input logic r, input logic f, input logic [NUM_IO-1:0] p,
                                       input logic [NUM_IO-1:0] o, input logic [NUM_OEB-1:0] e);
        logic [NUM_IO-1:0] s_old;
        logic [NUM_IO-1:0] nb;
        logic              all_diff;
        if (r) begin
            model_reset();
            return;
        end
        s_old = m_sync[SYNC-1];
        m_hist.push_front(s_old);
        if (m_hist.size() > FILT) void'(m_hist.pop_back());
        nb = m_in_buf;
        if (m_hist.size() == FILT) begin
            for (int b = 0; b < int'(NUM_IO); b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < int'(FILT); k++) begin
                    if (m_hist[k][b] == m_in_buf[b]) all_diff = 1'b0;
                end
                if (all_diff) nb[b] = ~m_in_buf[b];
            end
        end
        m_chg    = m_upd;
        m_upd    = |(nb ^ m_in_buf);
        m_in_buf = nb;
        m_sync.push_front(p);
        void'(m_sync.pop_back());
        if (!f) begin
            m_pipe.push_front({o, e});
            void'(m_pipe.pop_back());
        end
    endfunction

    task automatic step();
        logic r, f;
        logic [NUM_IO-1:0]  p, o;
        logic [NUM_OEB-1:0] e;
        logic [OW-1:0]      w;
        r = reset; f = freeze; p = pad; o = gout; e = goeb;
        @(posedge clock);
        model_edge(r, f, p, o, e);
        #1;
        w = m_pipe[OUTS-1];
        chk("in_buf",  64'(mgmt_gpio_in_buf),  64'(m_in_buf));
        chk("in_chg",  64'(in_changed),        64'(m_chg));
        chk("out_buf", 64'(mgmt_gpio_out_buf), 64'(w[OW-1:NUM_OEB]));
        chk("oeb_buf", 64'(mgmt_gpio_oeb_buf), 64'(w[NUM_OEB-1:0]));
    endtask

    initial begin
        model_reset();
        reset  = 1'b1;
        freeze = 1'b0;
        pad    = '0;
        gout   = '0;
        goeb   = '1;

        // T1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            pad    = NUM_IO'({$urandom, $urandom});
            gout   = NUM_IO'({$urandom, $urandom});
            goeb   = NUM_OEB'($urandom);
            freeze = 1'($urandom);
            step();
        end
        chk("t1_in_buf",  64'(mgmt_gpio_in_buf),  64'd0);
        chk("t1_out_buf", 64'(mgmt_gpio_out_buf), 64'd0);
        chk("t1_oeb_buf", 64'(mgmt_gpio_oeb_buf), 64'h7);
        chk("t1_in_chg",  64'(in_changed),        64'd0);

        reset = 1'b0; freeze = 1'b0; pad = '0; gout = '0; goeb = '1;
        for (int i = 0; i < 8; i++) step();

        // T2: input latency and in_changed timing
        pad[5] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("t2_in5", 64'(mgmt_gpio_in_buf[5]), 64'(e >= 6));
            chk("t2_chg", 64'(in_changed),          64'(e == 7));
        end

        // T3: 3-cycle glitch rejected, 4-cycle pulse accepted
        pad = '0;
        for (int i = 0; i < 10; i++) step();
        pad[0] = 1'b1;
        for (int i = 0; i < 3; i++) step();
        pad[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_glitch_in0", 64'(mgmt_gpio_in_buf[0]), 64'd0);
            chk("t3_glitch_chg", 64'(in_changed),          64'd0);
        end
        seen_high = 1'b0;
        pulses    = 0;
        pad[0]    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) pad[0] = 1'b0;
            step();
            seen_high = seen_high | mgmt_gpio_in_buf[0];
            if (in_changed) pulses++;
        end
        chk("t3_accept", 64'(seen_high), 64'd1);
        chk("t3_pulses", 64'(pulses),    64'd2);

        // T4: out and oeb stay aligned through the pipeline
        gout = 38'h2A_AAAA_AAAA;
        goeb = 3'b010;
        for (int e = 1; e <= 4; e++) begin
            step();
            gout = '0;
            goeb = 3'b101;
            if (e < 3) begin
                chk("t4_early_out", 64'(mgmt_gpio_out_buf), 64'd0);
                chk("t4_early_oeb", 64'(mgmt_gpio_oeb_buf), 64'h7);
            end else if (e == 3) begin
                chk("t4_out", 64'(mgmt_gpio_out_buf), 64'h2A_AAAA_AAAA);
                chk("t4_oeb", 64'(mgmt_gpio_oeb_buf), 64'h2);
            end else begin
                chk("t4_next_out", 64'(mgmt_gpio_out_buf), 64'd0);
                chk("t4_next_oeb", 64'(mgmt_gpio_oeb_buf), 64'h5);
            end
        end

        // T5: freeze holds the pipeline and drops frozen inputs
        gout = 38'h1;
        for (int i = 0; i < int'(OUTS); i++) step();
        chk("t5_pre", 64'(mgmt_gpio_out_buf), 64'h1);
        freeze = 1'b1;
        gout   = 38'h3F;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_frozen", 64'(mgmt_gpio_out_buf), 64'h1);
        end
        freeze = 1'b0;
        for (int e = 1; e <= int'(OUTS); e++) begin
            step();
            chk("t5_thaw", 64'(mgmt_gpio_out_buf), (e == int'(OUTS)) ? 64'h3F : 64'h1);
        end

        // T6: reset mid-filter discards the partial count
        pad[7] = 1'b1;
        for (int i = 0; i < 2; i++) step();
        reset = 1'b1;
        step();
        chk("t6_rst_in7", 64'(mgmt_gpio_in_buf[7]), 64'd0);
        chk("t6_rst_oeb", 64'(mgmt_gpio_oeb_buf),   64'h7);
        reset = 1'b0;
        first = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (first == 0 && mgmt_gpio_in_buf[7]) first = e;
        end
        chk("t6_latency", 64'(first), 64'(SYNC + FILT));

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset  = ($urandom_range(0, 63) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            gout   = NUM_IO'({$urandom, $urandom});
            goeb   = NUM_OEB'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                flip = NUM_IO'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
                pad  = pad ^ flip;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
